logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the single-bit two-input gate modules (y1/y2/y3 from a,b).
- Applies one of eight selectable bitwise two-operand logic functions to WIDTH-bit operands.
- Carries results through an elastic valid/ready register pipeline of STAGES slices.
- Sits between a stimulus/producer block and a consumer that may apply backpressure; also counts completed results.

---
 rtl/logic_unit_pkg.sv | 24 ++
 rtl/pipe_slice.sv | 28 ++
 rtl/logic_unit_pipe.sv | 61 ++++++
 tb/tb_logic_unit_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op codes and bitwise function shared by the pipe and its bench
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN, OP_PASSA
  } op_e;

  // Single-bit gate; callers loop over operand bits so width stays a caller parameter.
  function automatic logic logic_fn(op_e op, logic a, logic b);
    case (op)
      OP_AND:   logic_fn = a & b;
      OP_OR:    logic_fn = a | b;
      OP_XOR:   logic_fn = a ^ b;
      OP_NAND:  logic_fn = ~(a & b);
      OP_NOR:   logic_fn = ~(a | b);
      OP_XNOR:  logic_fn = ~(a ^ b);
      OP_ANDN:  logic_fn = a & ~b;
      default:  logic_fn = a;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - one elastic valid/ready register slice
module pipe_slice #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  // Ready whenever empty or the content leaves this cycle; never looks at up_valid.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - selectable bitwise logic unit behind an elastic pipeline
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic [CNT_W-1:0] done_cnt
);

  logic [WIDTH-1:0]          fn;
  logic [STAGES:0]           valid;
  logic [STAGES:0]           ready;
  logic [STAGES:0][WIDTH:0]  data;

  always_comb begin
    fn = '0;
    for (int i = 0; i < WIDTH; i++) fn[i] = logic_fn(op_e'(op), a[i], b[i]);
  end

  // Index 0 is the producer side, index STAGES the consumer side.
  assign valid[0]      = in_valid;
  assign data[0]       = {~|fn, fn};
  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    pipe_slice #(.W(WIDTH + 1)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .up_valid (valid[i]),
      .up_data  (data[i]),
      .up_ready (ready[i]),
      .dn_valid (valid[i+1]),
      .dn_data  (data[i+1]),
      .dn_ready (ready[i+1])
    );
  end

  assign out_valid = valid[STAGES];
  assign y         = data[STAGES][WIDTH-1:0];
  assign y_zero    = data[STAGES][WIDTH];

  always_ff @(posedge clk) begin
    if (rst)                        done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 1'b1;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] ey;
  } stim_t;

  stim_t            stim_q[$];
  logic [WIDTH:0]   sb_q[$];

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic [CNT_W-1:0] done_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_out = -1;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero),
    .done_cnt  (done_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] f, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = logic_fn(op_e'(f), x[i], z[i]);
    return r;
  endfunction

  task automatic push_rand(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s.op = 3'($urandom_range(0, 7));
      s.a  = WIDTH'($urandom);
      s.b  = WIDTH'($urandom);
      s.ey = ref_fn(s.op, s.a, s.b);
      stim_q.push_back(s);
    end
  endtask

  task automatic push_one(input logic [2:0] f, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] z, input logic [WIDTH-1:0] e);
    stim_t s;
    s.op = f; s.a = x; s.b = z; s.ey = e;
    stim_q.push_back(s);
  endtask

  // One clock: drive at edge+1, sample handshakes on the falling edge, check the counter after the edge.
  task automatic step();
    stim_t          s;
    logic [WIDTH:0] e;
    in_valid = (stim_q.size() > 0);
    if (stim_q.size() > 0) begin
      s  = stim_q[0];
      op = s.op; a = s.a; b = s.b;
    end
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        s = stim_q.pop_front();
        sb_q.push_back({(s.ey == '0), s.ey});
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("stale_out", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("y", y, e[WIDTH-1:0]);
          check("y_zero", y_zero, e[WIDTH]);
        end
        exp_cnt++;
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sb_q.delete();
      exp_cnt = '0;
    end
    check("done_cnt", done_cnt, exp_cnt);
  endtask

  task automatic drain(input string tag, input int limit);
    int k = 0;
    while ((stim_q.size() > 0 || sb_q.size() > 0) && k < limit) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, (k < limit), 1);
  endtask

  initial begin
    int             a0;
    int             o0;
    logic [WIDTH-1:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_y_zero", y_zero, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Every op on F0/CC, streamed back to back
    out_ready = 1'b1;
    first_acc = -1; first_out = -1; o0 = n_out;
    push_one(3'd0, 8'hF0, 8'hCC, 8'hC0);
    push_one(3'd1, 8'hF0, 8'hCC, 8'hFC);
    push_one(3'd2, 8'hF0, 8'hCC, 8'h3C);
    push_one(3'd3, 8'hF0, 8'hCC, 8'h3F);
    push_one(3'd4, 8'hF0, 8'hCC, 8'h03);
    push_one(3'd5, 8'hF0, 8'hCC, 8'hC3);
    push_one(3'd6, 8'hF0, 8'hCC, 8'h30);
    push_one(3'd7, 8'hF0, 8'hCC, 8'hF0);
    drain("ops", 40);
    check("ops_latency", first_out - first_acc, STAGES);
    check("ops_no_gaps", last_out - first_out, 7);
    check("ops_count", n_out - o0, 8);
    check("ops_done_cnt", done_cnt, 8);

    // Zero flag both ways
    push_one(3'd2, 8'hA5, 8'hA5, 8'h00);
    push_one(3'd1, 8'h00, 8'h01, 8'h01);
    drain("zero", 20);

    // Backpressure: capacity is STAGES, output holds while stalled
    out_ready = 1'b0;
    a0 = n_acc; o0 = n_out;
    push_rand(5);
    for (int i = 0; i < 5; i++) step();
    check("bp_accepts", n_acc - a0, STAGES);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    held = y;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_y_stable", y, held);
      check("bp_valid_stable", out_valid, 1);
    end
    out_ready = 1'b1;
    drain("bp", 40);
    check("bp_delivered", n_out - o0, 5);

    // Full pipe with simultaneous accept and output
    out_ready = 1'b0;
    push_rand(STAGES);
    for (int i = 0; i < STAGES + 1; i++) step();
    check("sim_full", in_ready, 0);
    push_rand(10);
    out_ready = 1'b1;
    a0 = n_acc; o0 = n_out;
    for (int i = 0; i < 10; i++) begin
      step();
      check("sim_in_ready", in_ready, 1);
    end
    check("sim_accepts", n_acc - a0, 10);
    check("sim_outputs", n_out - o0, 10);
    drain("sim", 40);

    // Reset with results in flight
    out_ready = 1'b0;
    push_rand(2);
    step(); step();
    check("mid_inflight", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_y", y, 0);
    check("mid_done_cnt", done_cnt, 0);
    check("mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("mid_no_stale", out_valid, 0);

    // Counter wraparound at 2^CNT_W
    o0 = n_out;
    push_rand(17);
    for (int k = 0; k < 60 && (n_out - o0) < 17; k++) begin
      step();
      if (n_out - o0 == 15) check("wrap_15", done_cnt, 15);
      if (n_out - o0 == 16) check("wrap_16", done_cnt, 0);
      if (n_out - o0 == 17) check("wrap_17", done_cnt, 1);
    end
    check("wrap_count", n_out - o0, 17);
    drain("wrap", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
